// File: rtl/pcpu_ex_pkg.sv
// Shared definitions for the PCPU execute stage: opcode codes and FSM states.
package pcpu_ex_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_NOP  = 5'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
    localparam logic [OP_W-1:0] OP_ADDC = 5'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd3;
    localparam logic [OP_W-1:0] OP_SUBC = 5'd4;
    localparam logic [OP_W-1:0] OP_CMP  = 5'd5;
    localparam logic [OP_W-1:0] OP_AND  = 5'd6;
    localparam logic [OP_W-1:0] OP_OR   = 5'd7;
    localparam logic [OP_W-1:0] OP_XOR  = 5'd8;
    localparam logic [OP_W-1:0] OP_SLL  = 5'd9;
    localparam logic [OP_W-1:0] OP_SRL  = 5'd10;
    localparam logic [OP_W-1:0] OP_SRA  = 5'd11;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd12;

    // IDLE and DONE both accept new work; DONE marks the cycle a product is presented.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } ex_state_t;

endpackage

// File: rtl/pcpu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per enabled edge,
// WIDTH steps after start. 'last' flags the edge on which 'product' is final.
module pcpu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               last,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     partial;

    // Next accumulator value: add multiplicand into the high half when the
    // current multiplier bit (acc LSB) is set, then shift the pair right.
    always_comb begin
        partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand_q} : '0);
        product = {partial, acc[WIDTH-1:1]};
        last    = (count == CW'(1));
    end

    // Operand capture on start, then one step per enabled edge until count empties.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= '0;
            mcand_q <= '0;
            acc     <= '0;
        end else if (enable) begin
            if (start) begin
                count   <= CW'(WIDTH);
                mcand_q <= mcand;
                acc     <= {{WIDTH{1'b0}}, mplier};
            end else if (count != '0) begin
                count   <= count - 1'b1;
                acc     <= product;
            end
        end
    end

endmodule

// File: rtl/pcpu_ex_unit.sv
// PCPU execute stage: registered single-cycle ALU with zf/nf/cf flags and an
// optional iterative MUL.
// Handshake: an op is taken when in_valid && enable && !busy; in_valid while
// busy is dropped. out_valid pulses for one enabled cycle per completed op.
module pcpu_ex_unit
    import pcpu_ex_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    output logic             busy,
    output logic             out_valid,
    output logic             out_wb,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             nf,
    output logic             cf,
    output ex_state_t        state_dbg
);

    localparam int SW = $clog2(WIDTH);

    ex_state_t          state, state_nx;
    logic [WIDTH-1:0]   result_nx, alu_out, flag_src;
    logic               zf_nx, nf_nx, cf_nx, out_valid_nx, out_wb_nx, upd_zn;
    logic [WIDTH:0]     arith;
    logic [SW-1:0]      shamt;
    logic               mul_start, mul_last;
    logic [2*WIDTH-1:0] mul_product;

    assign busy      = (state == ST_MUL);
    assign shamt     = reg_b[SW-1:0];
    assign state_dbg = state;

    generate
        if (MUL_EN) begin : g_mul
            pcpu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clock   (clock),
                .reset   (reset),
                .enable  (enable),
                .start   (mul_start),
                .mcand   (reg_a),
                .mplier  (reg_b),
                .last    (mul_last),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_last    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // Next-state, result and flag selection; arithmetic carries in bit WIDTH.
    always_comb begin
        state_nx     = state;
        result_nx    = result;
        zf_nx        = zf;
        nf_nx        = nf;
        cf_nx        = cf;
        out_valid_nx = 1'b0;
        out_wb_nx    = 1'b0;
        mul_start    = 1'b0;
        arith        = '0;
        alu_out      = '0;
        flag_src     = result;
        upd_zn       = 1'b0;
        if (state == ST_MUL) begin
            if (mul_last) begin
                state_nx     = ST_DONE;
                result_nx    = mul_product[WIDTH-1:0];
                flag_src     = mul_product[WIDTH-1:0];
                upd_zn       = 1'b1;
                cf_nx        = |mul_product[2*WIDTH-1:WIDTH];
                out_valid_nx = 1'b1;
                out_wb_nx    = 1'b1;
            end
        end else begin
            state_nx = ST_IDLE;
            if (in_valid) begin
                out_valid_nx = 1'b1;
                out_wb_nx    = 1'b1;
                upd_zn       = 1'b1;
                case (op)
                    OP_ADD: begin
                        arith = {1'b0, reg_a} + {1'b0, reg_b};
                        cf_nx = arith[WIDTH];
                    end
                    OP_ADDC: begin
                        arith = {1'b0, reg_a} + {1'b0, reg_b} + {{WIDTH{1'b0}}, cf};
                        cf_nx = arith[WIDTH];
                    end
                    OP_SUB, OP_CMP: begin
                        arith = {1'b0, reg_a} - {1'b0, reg_b};
                        cf_nx = arith[WIDTH];
                        out_wb_nx = (op == OP_SUB);
                    end
                    OP_SUBC: begin
                        arith = {1'b0, reg_a} - {1'b0, reg_b} - {{WIDTH{1'b0}}, cf};
                        cf_nx = arith[WIDTH];
                    end
                    OP_AND: begin alu_out = reg_a & reg_b; cf_nx = 1'b0; end
                    OP_OR:  begin alu_out = reg_a | reg_b; cf_nx = 1'b0; end
                    OP_XOR: begin alu_out = reg_a ^ reg_b; cf_nx = 1'b0; end
                    OP_SLL: alu_out = reg_a << shamt;
                    OP_SRL: alu_out = reg_a >> shamt;
                    OP_SRA: alu_out = $signed(reg_a) >>> shamt;
                    OP_MUL: begin
                        upd_zn    = 1'b0;
                        out_wb_nx = 1'b0;
                        if (MUL_EN) begin
                            state_nx     = ST_MUL;
                            mul_start    = 1'b1;
                            out_valid_nx = 1'b0;
                        end
                    end
                    default: begin
                        upd_zn    = 1'b0;
                        out_wb_nx = 1'b0;
                    end
                endcase
                if (op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP})
                    alu_out = arith[WIDTH-1:0];
                flag_src = alu_out;
                if (out_wb_nx)
                    result_nx = alu_out;
            end
        end
        if (upd_zn) begin
            zf_nx = ~|flag_src;
            nf_nx = flag_src[WIDTH-1];
        end
    end

    // State and output registers; enable low freezes everything including out_valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            result    <= '0;
            zf        <= 1'b0;
            nf        <= 1'b0;
            cf        <= 1'b0;
            out_valid <= 1'b0;
            out_wb    <= 1'b0;
        end else if (enable) begin
            state     <= state_nx;
            result    <= result_nx;
            zf        <= zf_nx;
            nf        <= nf_nx;
            cf        <= cf_nx;
            out_valid <= out_valid_nx;
            out_wb    <= out_wb_nx;
        end
    end

endmodule

// File: tb/tb_pcpu_ex_unit.sv
// Bench for pcpu_ex_unit: a 16-bit MUL-enabled instance and a 32-bit MUL-less one.
module tb_pcpu_ex_unit;
  import pcpu_ex_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic en16 = 1'b1, iv16 = 1'b0;
  logic [4:0] op16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic busy16, ov16, wb16, zf16, nf16, cf16;
  logic [15:0] res16;
  ex_state_t st16;

  logic en32 = 1'b1, iv32 = 1'b0;
  logic [4:0] op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic busy32, ov32, wb32, zf32, nf32, cf32;
  logic [31:0] res32;
  ex_state_t st32;

  int vectors = 0;
  int miscompares = 0;

  // scoreboard for multiplies: {out_valid, out_wb, result, zf, nf, cf}
  logic [20:0] exp_q[$];

  // reference model state for single-cycle traffic
  logic [15:0] m_res;
  logic m_zf, m_nf, m_cf, m_ov, m_wb;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a, b, res;
    logic        zf, nf, cf, wb;
  } vec_t;
  vec_t tbl[16];

  pcpu_ex_unit #(.WIDTH(16), .MUL_EN(1'b1)) dut16 (
    .clock(clk), .reset(rst), .enable(en16), .in_valid(iv16), .op(op16),
    .reg_a(a16), .reg_b(b16), .busy(busy16), .out_valid(ov16), .out_wb(wb16),
    .result(res16), .zf(zf16), .nf(nf16), .cf(cf16), .state_dbg(st16)
  );

  pcpu_ex_unit #(.WIDTH(32), .MUL_EN(1'b0)) dut32 (
    .clock(clk), .reset(rst), .enable(en32), .in_valid(iv32), .op(op32),
    .reg_a(a32), .reg_b(b32), .busy(busy32), .out_valid(ov32), .out_wb(wb32),
    .result(res32), .zf(zf32), .nf(nf32), .cf(cf32), .state_dbg(st32)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step16(input logic v, input logic [4:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    iv16 = v; op16 = o; a16 = x; b16 = y;
    @(posedge clk);
    #1;
  endtask

  task automatic step32(input logic v, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    iv32 = v; op32 = o; a32 = x; b32 = y;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: plain integer arithmetic modulo 2^16.
  task automatic model_apply(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
    longint ua, ub, t, sa, m;
    int amt;
    logic cin;
    ua = a; ub = b; m = 65536; amt = int'(b) % 16; cin = m_cf;
    m_ov = 1'b1; m_wb = 1'b1; t = m_res;
    case (o)
      OP_ADD:  begin t = ua + ub;       m_cf = (t >= m); t = t % m; end
      OP_ADDC: begin t = ua + ub + cin; m_cf = (t >= m); t = t % m; end
      OP_SUB:  begin m_cf = (ua < ub);       t = (ua - ub + m) % m; end
      OP_SUBC: begin m_cf = (ua < ub + cin); t = (ua - ub - cin + 2 * m) % m; end
      OP_CMP:  begin m_cf = (ua < ub);       t = (ua - ub + m) % m; m_wb = 1'b0; end
      OP_AND:  begin t = ua & ub; m_cf = 1'b0; end
      OP_OR:   begin t = ua | ub; m_cf = 1'b0; end
      OP_XOR:  begin t = ua ^ ub; m_cf = 1'b0; end
      OP_SLL:  t = (ua * (64'sd1 << amt)) % m;
      OP_SRL:  t = ua / (64'sd1 << amt);
      OP_SRA:  begin sa = (ua >= 32768) ? ua - m : ua; t = ((sa >>> amt) % m + m) % m; end
      default: m_wb = 1'b0;
    endcase
    if (o inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR,
                  OP_SLL, OP_SRL, OP_SRA}) begin
      m_zf = (t == 0);
      m_nf = (t >= 32768);
      if (m_wb) m_res = t[15:0];
    end
  endtask

  function automatic logic [4:0] pick_op();
    int s;
    s = $urandom_range(0, 12);
    case (s)
      0: return OP_ADD;   1: return OP_ADDC;  2: return OP_SUB;   3: return OP_SUBC;
      4: return OP_CMP;   5: return OP_AND;   6: return OP_OR;    7: return OP_XOR;
      8: return OP_SLL;   9: return OP_SRL;   10: return OP_SRA;  11: return OP_NOP;
      default: return 5'($urandom_range(13, 31));
    endcase
  endfunction

  initial begin
    int lat, seen;
    logic [15:0] ra, rb;
    logic [31:0] p;
    logic [20:0] e;
    logic ren, riv;
    logic [4:0] rop;

    tbl[0]  = '{OP_ADD,  16'hcccc, 16'h00ab, 16'hcd77, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{OP_ADD,  16'h3c00, 16'hc8cc, 16'h04cc, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{OP_ADDC, 16'h00ab, 16'h3c00, 16'h3cac, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{OP_SUB,  16'h3c00, 16'h3c00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{OP_CMP,  16'h3c00, 16'h3cac, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{OP_SUBC, 16'h3c00, 16'h3cac, 16'hff53, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{OP_AND,  16'hf0f0, 16'hff00, 16'hf000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{OP_OR,   16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{OP_ADD,  16'hffff, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{OP_SLL,  16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{OP_SRL,  16'h8000, 16'h000f, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{OP_XOR,  16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{OP_ADD,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{OP_SRA,  16'h8000, 16'h0004, 16'hf800, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{OP_NOP,  16'h1111, 16'h2222, 16'hf800, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{5'd31,   16'h3333, 16'h4444, 16'hf800, 1'b0, 1'b1, 1'b1, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset16", {busy16, ov16, wb16, res16, zf16, nf16, cf16}, '0);
    check("reset32", {busy32, ov32, wb32, res32, zf32, nf32, cf32}, '0);
    check("reset_state", st16, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // 32-bit, MUL disabled
    step32(1'b1, OP_ADD, 32'hffffffff, 32'h1);
    check("w32_add_wrap", {busy32, ov32, wb32, res32, zf32, nf32, cf32},
          {3'b011, 32'h0, 3'b101});
    step32(1'b1, OP_SRA, 32'h80000000, 32'h4);
    check("w32_sra", {busy32, ov32, wb32, res32, zf32, nf32, cf32},
          {3'b011, 32'hf8000000, 3'b011});
    step32(1'b1, OP_MUL, 32'h5, 32'h7);
    check("w32_mul_nop", {busy32, ov32, wb32, res32, zf32, nf32, cf32},
          {3'b010, 32'hf8000000, 3'b011});
    step32(1'b0, OP_NOP, 32'h0, 32'h0);
    check("w32_idle", {busy32, ov32, wb32, res32, zf32, nf32, cf32},
          {3'b000, 32'hf8000000, 3'b011});

    // 16-bit table, applied back to back
    for (int i = 0; i < 16; i++) begin
      step16(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      check($sformatf("tbl%0d", i), {busy16, ov16, wb16, res16, zf16, nf16, cf16},
            {1'b0, 1'b1, tbl[i].wb, tbl[i].res, tbl[i].zf, tbl[i].nf, tbl[i].cf});
    end
    step16(1'b0, OP_NOP, '0, '0);
    check("ov_drop", {busy16, ov16, wb16, res16, zf16, nf16, cf16},
          {3'b000, 16'hf800, 3'b011});

    // MUL 0123*0100 with an ignored ADD during busy, then an ADD in the DONE cycle
    step16(1'b1, OP_MUL, 16'h0123, 16'h0100);
    for (int j = 0; j <= W; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      check($sformatf("mul1_c%0d", j), {busy16, ov16}, {(j < W), (j == W)});
      if (j == 0) begin
        check("mul1_state", st16, ST_MUL);
        iv16 = 1'b0;
      end
      if (j == 2) begin iv16 = 1'b1; op16 = OP_ADD; a16 = 16'h0001; b16 = 16'h0001; end
      if (j == 3) iv16 = 1'b0;
    end
    check("mul1_out", {busy16, ov16, wb16, res16, zf16, nf16, cf16},
          {3'b011, 16'h2300, 3'b001});
    iv16 = 1'b1; op16 = OP_ADD; a16 = 16'h0001; b16 = 16'h0001;
    @(posedge clk); #1;
    check("done_accept", {busy16, ov16, wb16, res16, zf16, nf16, cf16},
          {3'b011, 16'h0002, 3'b000});
    iv16 = 1'b0;

    // MUL 00ff*00ff with enable low for three cycles
    step16(1'b1, OP_MUL, 16'h00ff, 16'h00ff);
    iv16 = 1'b0;
    for (int j = 1; j <= W + 3; j++) begin
      @(posedge clk); #1;
      check($sformatf("mul2_c%0d", j), {busy16, ov16}, {(j < W + 3), (j == W + 3)});
      if (j == 5) en16 = 1'b0;
      if (j == 8) en16 = 1'b1;
    end
    check("mul2_out", {busy16, ov16, wb16, res16, zf16, nf16, cf16},
          {3'b011, 16'hfe01, 3'b010});

    // reset in the middle of a multiply
    step16(1'b1, OP_MUL, 16'h1234, 16'h5678);
    iv16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_mul_reset", {busy16, ov16, wb16, res16, zf16, nf16, cf16}, '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int j = 0; j < 24; j++) begin
      @(posedge clk); #1;
      if (ov16 || busy16) seen++;
    end
    check("no_out_after_abort", seen, 0);

    // randomized single-cycle traffic against the model
    m_res = '0; m_zf = 1'b0; m_nf = 1'b0; m_cf = 1'b0; m_ov = 1'b0; m_wb = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ren = ($urandom_range(0, 9) != 0);
      riv = ($urandom_range(0, 3) != 0);
      rop = pick_op();
      ra = 16'($urandom_range(0, 65535));
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom_range(0, 65535));
      @(negedge clk);
      en16 = ren; iv16 = riv; op16 = rop; a16 = ra; b16 = rb;
      if (ren) begin
        if (riv) model_apply(rop, ra, rb);
        else begin m_ov = 1'b0; m_wb = 1'b0; end
      end
      @(posedge clk); #1;
      check($sformatf("rand%0d_op%0d", i, rop), {busy16, ov16, wb16, res16, zf16, nf16, cf16},
            {1'b0, m_ov, m_wb, m_res, m_zf, m_nf, m_cf});
    end
    en16 = 1'b1;
    iv16 = 1'b0;

    // randomized multiplies through the scoreboard
    for (int i = 0; i < 8; i++) begin
      ra = (i == 0) ? 16'hffff : 16'($urandom_range(0, 65535));
      rb = (i == 0) ? 16'hffff : (i == 1) ? 16'h0000 : 16'($urandom_range(0, 65535));
      p = 32'(longint'(ra) * longint'(rb));
      exp_q.push_back({2'b11, p[15:0], (p[15:0] == 16'h0), p[15], (p[31:16] != 16'h0)});
      step16(1'b1, OP_MUL, ra, rb);
      iv16 = 1'b0;
      lat = 0;
      while (lat < 40) begin
        @(posedge clk); #1;
        lat++;
        if (ov16) break;
      end
      check($sformatf("mul_rand%0d_latency", i), lat, W);
      e = exp_q.pop_front();
      check($sformatf("mul_rand%0d_out", i), {ov16, wb16, res16, zf16, nf16, cf16}, e);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pcpu_ex_unit.md
Name: pcpu_ex_unit

Overview:
Parametrised execute stage for the PCPU pipeline. Takes pre-muxed operands and an opcode from ID, produces a registered result plus zf/nf/cf flag register. Generalises the fixed 16-bit single-cycle ALU to WIDTH bits and adds an optional iterative multi-cycle multiply with busy/valid handshake.

Parameters:
WIDTH, 16, datapath width in bits (>= 8, power of two)
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as NOP (no flag or result change)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  global pipeline enable; 0 freezes all state including the MUL counter
in_valid  in  1  op/operands valid this cycle
op  in  5  opcode, shared define encoding
reg_a  in  WIDTH  operand A (immediates already merged by ID)
reg_b  in  WIDTH  operand B / shift amount
busy  out  1  MUL in progress; upstream must stall
out_valid  out  1  one-cycle pulse, result/flags updated
out_wb  out  1  result to be written back (0 for CMP and NOP)
result  out  WIDTH  registered result
zf  out  1  zero flag
nf  out  1  negative flag (result MSB)
cf  out  1  carry / borrow flag

Behaviour:
- Reset (async, any cycle, including mid-MUL): busy=0, out_valid=0, out_wb=0, result=0, zf=nf=cf=0, FSM=IDLE; an aborted MUL produces no output.
- enable=0: every register holds, out_valid holds its value, inputs ignored.
- Accept: in_valid=1 && enable=1 && busy=0. in_valid while busy=1 is ignored, not queued.
- Single-cycle ops (ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR, SLL, SRL, SRA): accepted at edge k -> result, flags, out_valid=1 visible after edge k. out_valid drops after edge k+1 if nothing new is accepted.
- Arithmetic is WIDTH+1 bits internally:
  - ADD: cf = carry out. ADDC: A+B+cf.
  - SUB: cf = borrow (A<B unsigned). SUBC: A-B-cf, cf = borrow.
  - CMP: computes SUB, updates flags, out_wb=0, result register unchanged.
- Logic ops update zf/nf and clear cf.
- Shifts: amount = reg_b[log2(WIDTH)-1:0]; SRA sign-fills; zf/nf update, cf unchanged.
- Flags are updated on the same edge as result, so back-to-back ADDC/SUBC use the carry of the immediately preceding op.
- FSM states: IDLE, MUL, DONE.
  - IDLE: on MUL accept -> MUL; load count=WIDTH, busy=1.
  - MUL: one shift-add step per enabled edge, count decrements. At count=1 -> DONE.
  - DONE: result = low WIDTH bits, zf/nf from low half, cf = (high half != 0), out_wb=1, out_valid=1, busy=0 -> IDLE.
  - MUL accepted at edge k gives out_valid after edge k+WIDTH. busy=1 after edges k..k+WIDTH-1.
  - A new op may be accepted in the same cycle out_valid is high.
- Unknown opcodes and NOP: out_valid=1, out_wb=0, no flag or result change.

Decomposition:
- Opcode encodings (ADD..SRA existing; MUL new, unused code) live in the shared define file with the other PCPU opcode macros.
- One sub-module: pcpu_mul_iter (WIDTH-parameterised shift-add multiplier with start/done, 2*WIDTH product), instantiated only when MUL_EN=1.

Test Plan:
- After reset: ADD A=cccc B=00ab -> next cycle result=cd77, zf=0, nf=1, cf=0, out_wb=1, out_valid=1.
- ADD 3c00+c8cc -> 04cc, cf=1; then ADDC 00ab+3c00 -> 3cac, cf=0.
- SUB 3c00-3c00 -> 0000, zf=1, cf=0. Then CMP 3c00,3cac -> out_wb=0, result stays 0000, zf=0, nf=1, cf=1. Then SUBC 3c00-3cac-cf -> ff53, nf=1, cf=1.
- MUL 0123*0100 (WIDTH=16): busy for 16 cycles, then result=2300, cf=1, nf=0, zf=0. An ADD on in_valid at cycle 3 of busy is ignored (no extra out_valid).
- MUL with enable=0 for 3 cycles mid-operation -> out_valid arrives 3 cycles later, same product. Reset asserted at MUL cycle 5 -> outputs 0 immediately, no out_valid afterwards.
- WIDTH=32, MUL_EN=0: ADD ffffffff+1 -> 00000000, zf=1, cf=1. SRA 80000000 by 4 -> f8000000. MUL -> out_wb=0, flags unchanged.
